// File: rtl/i2c_fifo_pkg.sv
// Shared FIFO sizing constants for the I2C bus-slave, I2C core and data FIFOs.
package i2c_fifo_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 3;
  localparam int FIFO_DEPTH = 1 << AWIDTH_DEF;

endpackage

// File: rtl/i2c_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module i2c_fifo_mem #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 3
) (
  input  logic              PCLK,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge PCLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers and sticky overflow/underflow flags.
module i2c_fifo
  import i2c_fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] WDATA,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] RDATA,
  input  logic              CLR_ERR,
  output logic              FULL,
  output logic              EMPTY,
  output logic [AWIDTH:0]   LEVEL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic              ERROR
);

  localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

  logic [AWIDTH:0] wr_ptr;
  logic [AWIDTH:0] rd_ptr;
  logic            push_ok;
  logic            pop_ok;
  logic            ovf_set;
  logic            udf_set;
  logic            ovf_q;
  logic            udf_q;

  assign EMPTY = (wr_ptr == rd_ptr);
  assign FULL  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                 (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);
  assign LEVEL = wr_ptr - rd_ptr;

  // A push at FULL still succeeds when a pop frees the head slot in the same cycle.
  assign push_ok = WR_EN && (!FULL || RD_EN);
  assign pop_ok  = RD_EN && !EMPTY;
  assign ovf_set = WR_EN && FULL && !RD_EN;
  assign udf_set = RD_EN && EMPTY;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      // New errors win over a simultaneous clear.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (CLR_ERR) ovf_q <= 1'b0;
      if (udf_set)      udf_q <= 1'b1;
      else if (CLR_ERR) udf_q <= 1'b0;
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;
  assign ERROR     = ovf_q | udf_q;

  i2c_fifo_mem #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_mem (
    .PCLK  (PCLK),
    .we    (push_ok && !PRESET),
    .waddr (wr_ptr[AWIDTH-1:0]),
    .wdata (WDATA),
    .raddr (rd_ptr[AWIDTH-1:0]),
    .rdata (RDATA)
  );

endmodule

// File: tb/tb_i2c_fifo.sv
// Directed bench for i2c_fifo: vector table plus hand sequences for full/empty/wrap/reset cases.
module tb_i2c_fifo;
  import i2c_fifo_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        WR_EN = 1'b0;
  logic [31:0] WDATA = '0;
  logic        RD_EN = 1'b0;
  logic [31:0] RDATA;
  logic        CLR_ERR = 1'b0;
  logic        FULL, EMPTY, OVERFLOW, UNDERFLOW, ERROR;
  logic [3:0]  LEVEL;

  int tests = 0;
  int fails = 0;

  always #5 PCLK = ~PCLK;

  i2c_fifo dut (
    .PCLK(PCLK), .PRESET(PRESET), .WR_EN(WR_EN), .WDATA(WDATA), .RD_EN(RD_EN),
    .RDATA(RDATA), .CLR_ERR(CLR_ERR), .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .ERROR(ERROR)
  );

  typedef struct {
    logic        rst, wr, rd, clr;
    logic [31:0] wd;
    logic [3:0]  lvl;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        full, empty, ovf, udf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic wr, logic rd, logic clr, logic [31:0] wd,
                              logic [3:0] lvl, logic chk_rd, logic [31:0] rdata,
                              logic full, logic empty, logic ovf, logic udf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd;
    v.lvl = lvl; v.chk_rd = chk_rd; v.rdata = rdata;
    v.full = full; v.empty = empty; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(string tag, logic [3:0] lvl, logic full, logic empty,
                           logic ovf, logic udf);
    chk({tag, ".level"}, 32'(LEVEL), 32'(lvl));
    chk({tag, ".full"}, 32'(FULL), 32'(full));
    chk({tag, ".empty"}, 32'(EMPTY), 32'(empty));
    chk({tag, ".overflow"}, 32'(OVERFLOW), 32'(ovf));
    chk({tag, ".underflow"}, 32'(UNDERFLOW), 32'(udf));
    chk({tag, ".error"}, 32'(ERROR), 32'(ovf | udf));
  endtask

  // Drive one cycle of inputs, clock it, and leave the bench 1 time unit after the edge.
  task automatic step(logic rst, logic wr, logic rd, logic clr, logic [31:0] wd);
    PRESET = rst; WR_EN = wr; RD_EN = rd; CLR_ERR = clr; WDATA = wd;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; CLR_ERR = 1'b0;
  endtask

  initial begin
    int lvl_m;
    logic [31:0] q[$];
    logic [31:0] last;
    int pushes;
    logic wr, rd;

    //             rst wr rd clr wdata   lvl chk rdata  full empty ovf udf
    vq.push_back(mk(1, 1, 1, 1, 32'h99, 0, 0, 0,      0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 32'h11, 1, 1, 32'h11, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 32'h22, 2, 1, 32'h11, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 32'h33, 3, 1, 32'h11, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,  2, 1, 32'h22, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 32'h55, 2, 1, 32'h33, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,  1, 1, 32'h55, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,  0, 0, 0,      0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,  0, 0, 0,      0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 32'h0,  0, 0, 0,      0, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 32'h44, 1, 1, 32'h44, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 1, 1, 32'h0,  0, 0, 0,      0, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 32'h0,  0, 0, 0,      0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 32'h0,  0, 0, 0,      0, 1, 0, 0));

    repeat (2) @(posedge PCLK);
    #1;
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].wr, vq[i].rd, vq[i].clr, vq[i].wd);
      chk_state($sformatf("vec%0d", i), vq[i].lvl, vq[i].full, vq[i].empty,
                vq[i].ovf, vq[i].udf);
      if (vq[i].chk_rd) chk($sformatf("vec%0d.rdata", i), RDATA, vq[i].rdata);
    end

    // Fill to depth, overflow attempt, then drain in order.
    for (int i = 0; i < FIFO_DEPTH; i++) step(0, 1, 0, 0, 32'(i));
    chk_state("fill", 4'd8, 1, 0, 0, 0);
    step(0, 1, 0, 0, 32'hFF);
    chk_state("ovf_push", 4'd8, 1, 0, 1, 0);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      chk($sformatf("drain%0d.rdata", i), RDATA, 32'(i));
      step(0, 0, 1, 0, 0);
    end
    chk_state("drained", 4'd0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    chk_state("clr_ovf", 4'd0, 0, 1, 0, 0);

    // Push with pop while full: head leaves, 0xAA enters, level stays at depth.
    for (int i = 0; i < FIFO_DEPTH; i++) step(0, 1, 0, 0, 32'h100 + 32'(i));
    step(0, 1, 1, 0, 32'hAA);
    chk_state("full_pushpop", 4'd8, 1, 0, 0, 0);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      last = RDATA;
      if (i < FIFO_DEPTH - 1) chk($sformatf("fpp%0d.rdata", i), RDATA, 32'h101 + 32'(i));
      step(0, 0, 1, 0, 0);
    end
    chk("fpp.last", last, 32'hAA);
    chk_state("fpp_drained", 4'd0, 0, 1, 0, 0);

    // Interleaved traffic across pointer wrap against a queue model.
    lvl_m = 0;
    pushes = 0;
    for (int i = 0; i < 40; i++) begin
      wr = (pushes < 20) && (i % 4 != 3);
      rd = (i >= 30) || (i % 3 != 0);
      if (lvl_m > 0 && rd) chk($sformatf("wrap%0d.rdata", i), RDATA, q[0]);
      step(0, wr, rd, 0, 32'hC000 + 32'(pushes));
      if (rd && lvl_m > 0) begin
        void'(q.pop_front());
        lvl_m--;
      end
      if (wr && (lvl_m < FIFO_DEPTH || rd)) begin
        q.push_back(32'hC000 + 32'(pushes));
        lvl_m++;
      end
      if (wr) pushes++;
      chk($sformatf("wrap%0d.level", i), 32'(LEVEL), 32'(lvl_m));
    end
    chk("wrap.pushes", 32'(pushes), 32'd20);
    step(0, 0, 0, 1, 0);
    chk_state("wrap_end", 4'd0, 0, 1, 0, 0);

    // Reset at level 5 with a pending push and a sticky error.
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 32'h500 + 32'(i));
    chk_state("pre_rst", 4'd5, 0, 0, 0, 1);
    step(1, 1, 0, 0, 32'hDEAD);
    chk_state("post_rst", 4'd0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 32'h77);
    chk("post_rst.rdata", RDATA, 32'h77);
    chk_state("post_rst_push", 4'd1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_fifo.md
I2C_FIFO -- requirements
Module: i2c_fifo

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32: data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 3: pointer width in bits; depth = 2**AWIDTH (8 entries).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port PCLK  input  1  clock; all state updates on its rising edge.
REQ-005 The block SHALL have port PRESET  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port WR_EN  input  1  push request; it is driven by the bus-slave write-enable.
REQ-007 The block SHALL have port WDATA  input  DWIDTH  push data.
REQ-008 The block SHALL have port RD_EN  input  1  pop request.
REQ-009 The block SHALL have port RDATA  output  DWIDTH  head-of-queue data, first-word fall-through.
REQ-010 The block SHALL have port CLR_ERR  input  1  clears the sticky error flags.
REQ-011 The block SHALL have port FULL  output  1  level equals depth.
REQ-012 The block SHALL have port EMPTY  output  1  level equals 0; it feeds the TX_EMPTY/RX_EMPTY interrupt inputs.
REQ-013 The block SHALL have port LEVEL  output  AWIDTH+1  number of stored words, 0..depth.
REQ-014 The block SHALL have port OVERFLOW  output  1  sticky: a push was rejected.
REQ-015 The block SHALL have port UNDERFLOW  output  1  sticky: a pop was rejected.
REQ-016 The block SHALL have port ERROR  output  1  OVERFLOW OR UNDERFLOW; it feeds the bus-slave ERROR input.

Function
REQ-017 RDATA SHALL equal the entry at the read pointer combinationally, with zero-cycle latency from pointer update; RDATA is don't-care while EMPTY=1.
REQ-018 A push (WR_EN=1, FULL=0) SHALL store WDATA at the write pointer and increment the pointer modulo depth at the same edge.
REQ-019 A pop (RD_EN=1, EMPTY=0) SHALL increment the read pointer modulo depth; the next word appears on RDATA in the following cycle.
REQ-020 Pointers SHALL be AWIDTH+1 bits with a wrap bit; FULL = (addresses equal, wrap bits differ); EMPTY = (pointers equal).
REQ-021 LEVEL SHALL equal write pointer minus read pointer in AWIDTH+1-bit modulo arithmetic; FULL, EMPTY and LEVEL are registered-state derived, with no input-to-output path.
REQ-022 Push and pop in the same cycle with 0<LEVEL<depth SHALL both succeed, leaving LEVEL unchanged.
REQ-023 When FULL=1, push+pop in the same cycle SHALL both succeed: the head is popped, the new word is stored, and LEVEL stays at depth.
REQ-024 When EMPTY=1, push+pop in the same cycle SHALL perform the push only, set UNDERFLOW, and yield LEVEL=1.
REQ-025 A push with FULL=1 and no pop SHALL be dropped (no state change) and SHALL set OVERFLOW at the next edge.
REQ-026 A pop with EMPTY=1 SHALL be ignored and SHALL set UNDERFLOW at the next edge.
REQ-027 CLR_ERR=1 SHALL clear OVERFLOW and UNDERFLOW at the next edge; a new error in the same cycle SHALL take priority, leaving the flag set.

Reset
REQ-028 On PRESET=1 at a PCLK edge the block SHALL set both pointers to 0, LEVEL=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0 and ERROR=0.
REQ-029 Reset SHALL dominate WR_EN, RD_EN and CLR_ERR in the same cycle; reset mid-operation discards all stored words.
REQ-030 The storage array SHALL NOT be reset.

Structure
REQ-031 Package i2c_fifo_pkg SHALL hold the default DWIDTH/AWIDTH constants and the depth constant shared with the bus-slave and I2C core.
REQ-032 Storage SHALL be a sub-module i2c_fifo_mem with one synchronous write port and one asynchronous read port.
REQ-033 Pointer, flag and error logic SHALL reside in i2c_fifo.

Verification
REQ-034 The bench SHALL cover: reset, then push 0x11,0x22,0x33 -> LEVEL=3, RDATA=0x11; pop -> RDATA=0x22, LEVEL=2.
REQ-035 The bench SHALL cover: push 8 words 0..7 -> FULL=1, LEVEL=8; 9th push 0xFF -> dropped, OVERFLOW=1, ERROR=1; pop all -> 0..7 in order.
REQ-036 The bench SHALL cover: pop with EMPTY=1 -> UNDERFLOW=1, LEVEL=0; CLR_ERR pulse -> ERROR=0 next cycle.
REQ-037 The bench SHALL cover: at FULL, push 0xAA with pop -> LEVEL=8, no OVERFLOW, and 0xAA is the last word read.
REQ-038 The bench SHALL cover: 20 pushes interleaved with pops (pointer wrap) -> data order preserved, LEVEL is correct every cycle.
REQ-039 The bench SHALL cover: PRESET asserted at LEVEL=5 with WR_EN=1 -> next cycle EMPTY=1, LEVEL=0, all flags 0.
